// File: rtl/seq_gen_tx.sv
// seq_gen_tx: serial pattern transmitter, MSB-first, repeat_n frames with GAP idle cycles.
// Optional SEQ_GEN_PARITY_EN appends an even-parity bit after each frame.
module seq_gen_tx #(
  parameter int               WIDTH   = 6,
  parameter logic [WIDTH-1:0] PATTERN = 6'b101011,
  parameter int               GAP     = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       repeat_n,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             out,
  output logic             busy,
  output logic             done,
  output logic [7:0]       frames_left
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LD = CW'(WIDTH - 1);
  localparam logic [3:0] GAP_LD = 4'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP,
    S_DONE,
    S_PAR
  } state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [3:0]       gcnt, gcnt_n;
  logic [7:0]       fl, fl_n;
  logic [WIDTH-1:0] pat, pat_n;
  logic             frame_end;

  // state and datapath registers; reset also restores the default pattern
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      gcnt  <= '0;
      fl    <= '0;
      pat   <= PATTERN;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      gcnt  <= gcnt_n;
      fl    <= fl_n;
      pat   <= pat_n;
    end
  end

  // next-state: load/start in IDLE, bit shifting, gap timing, frame accounting
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    gcnt_n    = gcnt;
    fl_n      = fl;
    pat_n     = pat;
    frame_end = 1'b0;
    case (state)
      S_IDLE: begin
        if (load_valid) pat_n = load_data;
        if (start && repeat_n != 8'd0) begin
          state_n = S_SHIFT;
          fl_n    = repeat_n;
          cnt_n   = CNT_LD;
        end
      end
      S_SHIFT: begin
        if (cnt == '0) begin
`ifdef SEQ_GEN_PARITY_EN
          state_n = S_PAR;
`else
          frame_end = 1'b1;
`endif
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      S_PAR: frame_end = 1'b1;
      S_GAP: begin
        if (gcnt == 4'd0) begin
          state_n = S_SHIFT;
          cnt_n   = CNT_LD;
        end else begin
          gcnt_n = gcnt - 4'd1;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (frame_end) begin
      if (fl > 8'd1) begin
        fl_n  = fl - 8'd1;
        cnt_n = CNT_LD;
        if (GAP == 0) begin
          state_n = S_SHIFT;
        end else begin
          state_n = S_GAP;
          gcnt_n  = GAP_LD;
        end
      end else begin
        fl_n    = 8'd0;
        state_n = S_DONE;
      end
    end
  end

  // outputs decoded purely from registered state
  always_comb begin
    out = 1'b0;
    if (state == S_SHIFT) out = pat[cnt];
    else if (state == S_PAR) out = ^pat;
    busy        = (state != S_IDLE);
    done        = (state == S_DONE);
    load_ready  = (state == S_IDLE);
    frames_left = fl;
  end

endmodule
